// File: rtl/package_frame_sequencer.sv
// package_frame_sequencer
// Pulls bytes one at a time from the BlueTooth response FIFO and hunts for
// the package start byte. Each package is checked against its trailing
// checksum byte. PACKAGE_NUM consecutive good packages form one frame.
// The frame is offered to the window writer on a valid/ready handshake.
// Sync and checksum errors are counted for debug.
module package_frame_sequencer #(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    PACKAGE_SIZE  = 11,
  parameter int                    PACKAGE_NUM   = 4,
  parameter logic [DATA_WIDTH-1:0] START_BYTE    = 8'h55,
  parameter int                    PKG_IDX_WIDTH = 2,
  parameter int                    FRAME_WIDTH   = PACKAGE_SIZE*PACKAGE_NUM*DATA_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sync_clr,
  input  logic                     fifo_empty,
  output logic                     fifo_r_en,
  input  logic [DATA_WIDTH-1:0]    fifo_data_i,
  output logic [FRAME_WIDTH-1:0]   frame_o,
  output logic                     frame_vld,
  input  logic                     frame_rdy,
  output logic [PKG_IDX_WIDTH-1:0] pkg_idx_o,
  output logic [7:0]               sync_err_cnt,
  output logic [7:0]               sum_err_cnt
);

  localparam int CNT_WIDTH = $clog2(PACKAGE_SIZE);

  // Byte position of the checksum inside a package, and the last package
  // index of a frame.
  localparam logic [CNT_WIDTH-1:0]     LAST_BYTE = CNT_WIDTH'(PACKAGE_SIZE - 1);
  localparam logic [CNT_WIDTH-1:0]     CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [PKG_IDX_WIDTH-1:0] LAST_PKG  = PKG_IDX_WIDTH'(PACKAGE_NUM - 1);
  localparam logic [PKG_IDX_WIDTH-1:0] PKG_ONE   = PKG_IDX_WIDTH'(1);

  typedef enum logic [1:0] {
    StHunt = 2'd0,
    StBody = 2'd1,
    StHold = 2'd2
  } stateT;

  stateT                    stateReg,     stateNext;
  logic                     rdPendingReg, rdPendingNext;
  logic [CNT_WIDTH-1:0]     byteCntReg,   byteCntNext;
  logic [DATA_WIDTH-1:0]    sumReg,       sumNext;
  logic [PKG_IDX_WIDTH-1:0] pkgIdxReg,    pkgIdxNext;
  logic [FRAME_WIDTH-1:0]   frameReg,     frameNext;
  logic                     frameVldReg,  frameVldNext;
  logic [7:0]               syncErrReg,   syncErrNext;
  logic [7:0]               sumErrReg,    sumErrNext;

  // The new byte enters at the LSB end so the first byte of a frame ends up
  // in the MSBs once the whole frame has been shifted in.
  logic [FRAME_WIDTH-1:0] frameShifted;
  assign frameShifted = {frameReg[FRAME_WIDTH-DATA_WIDTH-1:0], fifo_data_i};

  // Debug counters stick at their maximum instead of wrapping.
  function automatic logic [7:0] satInc(input logic [7:0] value);
    return (value == 8'hFF) ? value : value + 8'd1;
  endfunction

  // State register: FSM state plus all datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg     <= StHunt;
      rdPendingReg <= 1'b0;
      byteCntReg   <= '0;
      sumReg       <= '0;
      pkgIdxReg    <= '0;
      frameReg     <= '0;
      frameVldReg  <= 1'b0;
      syncErrReg   <= '0;
      sumErrReg    <= '0;
    end else begin
      stateReg     <= stateNext;
      rdPendingReg <= rdPendingNext;
      byteCntReg   <= byteCntNext;
      sumReg       <= sumNext;
      pkgIdxReg    <= pkgIdxNext;
      frameReg     <= frameNext;
      frameVldReg  <= frameVldNext;
      syncErrReg   <= syncErrNext;
      sumErrReg    <= sumErrNext;
    end
  end

  // Next-state logic: byte capture, checksum decision and frame handshake.
  always_comb begin
    stateNext     = stateReg;
    byteCntNext   = byteCntReg;
    sumNext       = sumReg;
    pkgIdxNext    = pkgIdxReg;
    frameNext     = frameReg;
    frameVldNext  = frameVldReg;
    syncErrNext   = syncErrReg;
    sumErrNext    = sumErrReg;
    // A read issued this cycle returns data that is captured next edge;
    // a pending read is always consumed on the edge that follows it.
    rdPendingNext = fifo_r_en;

    if (sync_clr) begin
      // Flush wins over any capture or handshake in the same cycle; a byte
      // returning from a read issued last cycle is simply dropped.
      stateNext     = StHunt;
      rdPendingNext = 1'b0;
      byteCntNext   = '0;
      sumNext       = '0;
      pkgIdxNext    = '0;
      frameNext     = '0;
      frameVldNext  = 1'b0;
      syncErrNext   = '0;
      sumErrNext    = '0;
    end else begin
      unique case (stateReg)
        StHunt: begin
          if (rdPendingReg) begin
            if (fifo_data_i == START_BYTE) begin
              frameNext   = frameShifted;
              sumNext     = START_BYTE;
              byteCntNext = CNT_ONE;
              stateNext   = StBody;
            end else begin
              syncErrNext = satInc(syncErrReg);
            end
          end
        end

        StBody: begin
          if (rdPendingReg) begin
            if (byteCntReg != LAST_BYTE) begin
              frameNext   = frameShifted;
              sumNext     = sumReg + fifo_data_i;
              byteCntNext = byteCntReg + CNT_ONE;
            end else if (fifo_data_i == sumReg) begin
              frameNext   = frameShifted;
              byteCntNext = '0;
              if (pkgIdxReg == LAST_PKG) begin
                frameVldNext = 1'b1;
                stateNext    = StHold;
              end else begin
                pkgIdxNext = pkgIdxReg + PKG_ONE;
                stateNext  = StHunt;
              end
            end else begin
              // Bad checksum: the whole partial frame is abandoned. The
              // frame register keeps stale bytes, which are shifted out by
              // the next full frame before frame_vld can rise again.
              byteCntNext = '0;
              pkgIdxNext  = '0;
              sumErrNext  = satInc(sumErrReg);
              stateNext   = StHunt;
            end
          end
        end

        StHold: begin
          if (frame_rdy) begin
            frameVldNext = 1'b0;
            pkgIdxNext   = '0;
            stateNext    = StHunt;
          end
        end

        default: begin
          stateNext = StHunt;
        end
      endcase
    end
  end

  // Output logic: one outstanding read at most, none while a frame is held.
  // The read is also suppressed during reset and flush so that no FIFO byte
  // is popped and then thrown away by the clear.
  always_comb begin
    fifo_r_en = rst_n && !sync_clr && !fifo_empty && !rdPendingReg &&
                (stateReg != StHold);
  end

  assign frame_o      = frameReg;
  assign frame_vld    = frameVldReg;
  assign pkg_idx_o    = pkgIdxReg;
  assign sync_err_cnt = syncErrReg;
  assign sum_err_cnt  = sumErrReg;

endmodule

// File: tb/tb_package_frame_sequencer.sv
// tb_package_frame_sequencer
// Directed bench: a small FIFO model feeds hand-built packages into the
// sequencer and each scenario task checks the frame, handshake and counters.
module tb_package_frame_sequencer;

  localparam int FW = 352;

  localparam logic [87:0] PKG_SPEC = 88'h55_51_01_00_02_00_03_00_04_00_B0;
  localparam logic [87:0] PKG_BAD  = 88'h55_51_01_00_02_00_03_00_04_00_B1;
  localparam logic [87:0] PKG_A    = 88'h55_10_20_30_40_50_60_70_80_90_25;
  localparam logic [87:0] PKG_B    = 88'h55_FF_FF_FF_FF_FF_FF_FF_FF_FF_4C;
  localparam logic [87:0] PKG_C    = 88'h55_01_02_03_04_05_06_07_08_09_82;
  localparam logic [87:0] PKG_D    = 88'h55_55_00_00_00_00_00_00_00_00_AA;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sync_clr = 1'b0;
  logic          fifo_empty;
  logic          fifo_r_en;
  logic [7:0]    fifo_data_i = 8'h00;
  logic [FW-1:0] frame_o;
  logic          frame_vld;
  logic          frame_rdy = 1'b1;
  logic [1:0]    pkg_idx_o;
  logic [7:0]    sync_err_cnt;
  logic [7:0]    sum_err_cnt;

  int errors = 0;
  int checks = 0;

  // FIFO model: bytes are pushed by the tasks, popped on a read strobe and
  // presented the cycle after the strobe.
  logic [7:0]    fifoMem [0:1023];
  int            wrPtr = 0;
  int            rdPtr = 0;
  logic          emptyForce = 1'b0;
  logic          toggleEn = 1'b0;
  logic [FW-1:0] expFrame = '0;

  assign fifo_empty = (rdPtr == wrPtr) || emptyForce;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (fifo_r_en) begin
      fifo_data_i <= fifoMem[rdPtr[9:0]];
      rdPtr       <= rdPtr + 1;
    end
  end

  always @(posedge clk) emptyForce <= toggleEn ? ~emptyForce : 1'b0;

  package_frame_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sync_clr     (sync_clr),
    .fifo_empty   (fifo_empty),
    .fifo_r_en    (fifo_r_en),
    .fifo_data_i  (fifo_data_i),
    .frame_o      (frame_o),
    .frame_vld    (frame_vld),
    .frame_rdy    (frame_rdy),
    .pkg_idx_o    (pkg_idx_o),
    .sync_err_cnt (sync_err_cnt),
    .sum_err_cnt  (sum_err_cnt)
  );

  task automatic push_byte(input logic [7:0] b);
    fifoMem[wrPtr[9:0]] = b;
    wrPtr++;
  endtask

  // Push one 11-byte package and shift it into the expected frame.
  task automatic push_pkg(input logic [87:0] p);
    logic [7:0] b;
    for (int i = 0; i < 11; i++) begin
      b = p[87-8*i -: 8];
      push_byte(b);
      expFrame = {expFrame[FW-9:0], b};
    end
  endtask

  task automatic wait_vld(input int maxCyc, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < maxCyc; i++) begin
      @(negedge clk);
      if (frame_vld) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_idle(input int maxCyc, output bit idle);
    idle = 1'b0;
    for (int i = 0; i < maxCyc; i++) begin
      @(negedge clk);
      if (rdPtr == wrPtr && !fifo_r_en) begin
        idle = 1'b1;
        break;
      end
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (frame_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", frame_vld); end
    checks++; if (frame_o !== '0) begin errors++; $display("FAIL reset_frame: got %h want 0", frame_o); end
    checks++; if (pkg_idx_o !== 2'd0) begin errors++; $display("FAIL reset_pkg_idx: got %0d want 0", pkg_idx_o); end
    checks++; if (sync_err_cnt !== 8'd0) begin errors++; $display("FAIL reset_sync_err: got %0d want 0", sync_err_cnt); end
    checks++; if (sum_err_cnt !== 8'd0) begin errors++; $display("FAIL reset_sum_err: got %0d want 0", sum_err_cnt); end
    checks++; if (fifo_r_en !== 1'b0) begin errors++; $display("FAIL reset_r_en: got %b want 0", fifo_r_en); end
    rst_n = 1'b1;
    @(negedge clk);
    $display("test_reset: reset released");
  endtask

  task automatic test_basic();
    bit seen;
    frame_rdy = 1'b1;
    for (int i = 0; i < 4; i++) push_pkg(PKG_SPEC);
    wait_vld(300, seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL basic_vld: got %b want 1", seen); end
    checks++; if (frame_o !== expFrame) begin errors++; $display("FAIL basic_frame: got %h want %h", frame_o, expFrame); end
    checks++; if (frame_o[351:344] !== 8'h55) begin errors++; $display("FAIL basic_msb: got %h want 55", frame_o[351:344]); end
    checks++; if (frame_o[7:0] !== 8'hB0) begin errors++; $display("FAIL basic_lsb: got %h want b0", frame_o[7:0]); end
    checks++; if (sync_err_cnt !== 8'd0) begin errors++; $display("FAIL basic_sync_err: got %0d want 0", sync_err_cnt); end
    checks++; if (sum_err_cnt !== 8'd0) begin errors++; $display("FAIL basic_sum_err: got %0d want 0", sum_err_cnt); end
    @(negedge clk);
    checks++; if (frame_vld !== 1'b0) begin errors++; $display("FAIL basic_vld_one_cycle: got %b want 0", frame_vld); end
    checks++; if (pkg_idx_o !== 2'd0) begin errors++; $display("FAIL basic_pkg_idx: got %0d want 0", pkg_idx_o); end
    $display("test_basic: frame %h..%h", frame_o[351:344], frame_o[7:0]);
  endtask

  task automatic test_hunt();
    bit seen;
    push_byte(8'h00);
    push_byte(8'hAA);
    push_byte(8'h13);
    push_pkg(PKG_A);
    push_pkg(PKG_B);
    push_pkg(PKG_C);
    push_pkg(PKG_D);
    wait_vld(300, seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL hunt_vld: got %b want 1", seen); end
    checks++; if (frame_o !== expFrame) begin errors++; $display("FAIL hunt_frame: got %h want %h", frame_o, expFrame); end
    checks++; if (frame_o[351:264] !== PKG_A) begin errors++; $display("FAIL hunt_first_pkg: got %h want %h", frame_o[351:264], PKG_A); end
    checks++; if (sync_err_cnt !== 8'd3) begin errors++; $display("FAIL hunt_sync_err: got %0d want 3", sync_err_cnt); end
    checks++; if (sum_err_cnt !== 8'd0) begin errors++; $display("FAIL hunt_sum_err: got %0d want 0", sum_err_cnt); end
    @(negedge clk);
    $display("test_hunt: frame accepted, sync_err_cnt=%0d", sync_err_cnt);
  endtask

  task automatic test_checksum();
    bit seen;
    bit errSeen;
    push_pkg(PKG_SPEC);
    push_pkg(PKG_BAD);
    errSeen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sum_err_cnt != 8'd0) begin
        errSeen = 1'b1;
        break;
      end
    end
    checks++; if (errSeen !== 1'b1) begin errors++; $display("FAIL cksum_err_seen: got %b want 1", errSeen); end
    checks++; if (sum_err_cnt !== 8'd1) begin errors++; $display("FAIL cksum_sum_err: got %0d want 1", sum_err_cnt); end
    checks++; if (pkg_idx_o !== 2'd0) begin errors++; $display("FAIL cksum_pkg_idx: got %0d want 0", pkg_idx_o); end
    checks++; if (frame_vld !== 1'b0) begin errors++; $display("FAIL cksum_no_vld: got %b want 0", frame_vld); end
    push_pkg(PKG_B);
    push_pkg(PKG_C);
    push_pkg(PKG_D);
    push_pkg(PKG_A);
    wait_vld(300, seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL cksum_vld: got %b want 1", seen); end
    checks++; if (rdPtr !== wrPtr) begin errors++; $display("FAIL cksum_early_vld: bytes read %0d want %0d", rdPtr, wrPtr); end
    checks++; if (frame_o !== expFrame) begin errors++; $display("FAIL cksum_frame: got %h want %h", frame_o, expFrame); end
    checks++; if (sum_err_cnt !== 8'd1) begin errors++; $display("FAIL cksum_sum_err_after: got %0d want 1", sum_err_cnt); end
    checks++; if (sync_err_cnt !== 8'd3) begin errors++; $display("FAIL cksum_sync_err: got %0d want 3", sync_err_cnt); end
    @(negedge clk);
    $display("test_checksum: frame accepted, sum_err_cnt=%0d", sum_err_cnt);
  endtask

  task automatic test_empty_toggle();
    bit seen;
    bit prevREn;
    int badEmpty;
    int badB2B;
    seen     = 1'b0;
    prevREn  = 1'b0;
    badEmpty = 0;
    badB2B   = 0;
    toggleEn = 1'b1;
    push_pkg(PKG_D);
    push_pkg(PKG_C);
    push_pkg(PKG_SPEC);
    push_pkg(PKG_B);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (fifo_r_en && fifo_empty) badEmpty++;
      if (fifo_r_en && prevREn) badB2B++;
      prevREn = fifo_r_en;
      if (frame_vld) begin
        seen = 1'b1;
        break;
      end
    end
    toggleEn = 1'b0;
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL toggle_vld: got %b want 1", seen); end
    checks++; if (badEmpty !== 0) begin errors++; $display("FAIL toggle_read_empty: got %0d reads want 0", badEmpty); end
    checks++; if (badB2B !== 0) begin errors++; $display("FAIL toggle_read_pending: got %0d reads want 0", badB2B); end
    checks++; if (frame_o !== expFrame) begin errors++; $display("FAIL toggle_frame: got %h want %h", frame_o, expFrame); end
    checks++; if (sum_err_cnt !== 8'd1) begin errors++; $display("FAIL toggle_sum_err: got %0d want 1", sum_err_cnt); end
    @(negedge clk);
    $display("test_empty_toggle: frame accepted under toggling empty");
  endtask

  task automatic test_hold();
    bit seen;
    frame_rdy = 1'b0;
    push_pkg(PKG_C);
    push_pkg(PKG_A);
    push_pkg(PKG_D);
    push_pkg(PKG_SPEC);
    push_byte(8'h55);
    push_byte(8'h51);
    push_byte(8'h01);
    wait_vld(300, seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL hold_vld: got %b want 1", seen); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++; if (frame_vld !== 1'b1) begin errors++; $display("FAIL hold_vld_stay cycle %0d: got %b want 1", i, frame_vld); end
      checks++; if (frame_o !== expFrame) begin errors++; $display("FAIL hold_frame cycle %0d: got %h want %h", i, frame_o, expFrame); end
      checks++; if (fifo_r_en !== 1'b0) begin errors++; $display("FAIL hold_no_read cycle %0d: got %b want 0", i, fifo_r_en); end
    end
    frame_rdy = 1'b1;
    @(negedge clk);
    checks++; if (frame_vld !== 1'b0) begin errors++; $display("FAIL hold_release_vld: got %b want 0", frame_vld); end
    checks++; if (pkg_idx_o !== 2'd0) begin errors++; $display("FAIL hold_release_pkg_idx: got %0d want 0", pkg_idx_o); end
    checks++; if (fifo_r_en !== 1'b1) begin errors++; $display("FAIL hold_reads_resume: got %b want 1", fifo_r_en); end
    $display("test_hold: frame held 20 cycles then accepted");
  endtask

  task automatic test_sync_clr();
    bit idle;
    bit seen;
    wait_idle(100, idle);
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL clr_drain1: got %b want 1", idle); end
    sync_clr = 1'b1;
    @(negedge clk);
    sync_clr = 1'b0;
    push_byte(8'h01);
    push_pkg(PKG_SPEC);
    push_pkg(PKG_SPEC);
    push_byte(8'h55);
    push_byte(8'h51);
    push_byte(8'h01);
    wait_idle(200, idle);
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL clr_drain2: got %b want 1", idle); end
    checks++; if (pkg_idx_o !== 2'd2) begin errors++; $display("FAIL clr_pre_pkg_idx: got %0d want 2", pkg_idx_o); end
    checks++; if (sync_err_cnt !== 8'd1) begin errors++; $display("FAIL clr_pre_sync_err: got %0d want 1", sync_err_cnt); end
    checks++; if (sum_err_cnt !== 8'd0) begin errors++; $display("FAIL clr_pre_sum_err: got %0d want 0", sum_err_cnt); end
    sync_clr = 1'b1;
    @(negedge clk);
    sync_clr = 1'b0;
    checks++; if (pkg_idx_o !== 2'd0) begin errors++; $display("FAIL clr_pkg_idx: got %0d want 0", pkg_idx_o); end
    checks++; if (sync_err_cnt !== 8'd0) begin errors++; $display("FAIL clr_sync_err: got %0d want 0", sync_err_cnt); end
    checks++; if (frame_vld !== 1'b0) begin errors++; $display("FAIL clr_vld: got %b want 0", frame_vld); end
    push_pkg(PKG_B);
    push_pkg(PKG_D);
    push_pkg(PKG_A);
    push_pkg(PKG_C);
    wait_vld(300, seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL clr_after_vld: got %b want 1", seen); end
    checks++; if (frame_o !== expFrame) begin errors++; $display("FAIL clr_after_frame: got %h want %h", frame_o, expFrame); end
    checks++; if (sum_err_cnt !== 8'd0) begin errors++; $display("FAIL clr_after_sum_err: got %0d want 0", sum_err_cnt); end
    checks++; if (sync_err_cnt !== 8'd0) begin errors++; $display("FAIL clr_after_sync_err: got %0d want 0", sync_err_cnt); end
    @(negedge clk);
    $display("test_sync_clr: flush mid-frame, next frame accepted");
  endtask

  task automatic test_reset_hold();
    bit seen;
    frame_rdy = 1'b0;
    push_pkg(PKG_A);
    push_pkg(PKG_A);
    push_pkg(PKG_B);
    push_pkg(PKG_B);
    wait_vld(300, seen);
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL rsthold_vld: got %b want 1", seen); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (frame_vld !== 1'b0) begin errors++; $display("FAIL rsthold_vld_async: got %b want 0", frame_vld); end
    checks++; if (frame_o !== '0) begin errors++; $display("FAIL rsthold_frame: got %h want 0", frame_o); end
    checks++; if (pkg_idx_o !== 2'd0) begin errors++; $display("FAIL rsthold_pkg_idx: got %0d want 0", pkg_idx_o); end
    @(negedge clk);
    rst_n = 1'b1;
    frame_rdy = 1'b1;
    @(negedge clk);
    checks++; if (frame_vld !== 1'b0) begin errors++; $display("FAIL rsthold_vld_after: got %b want 0", frame_vld); end
    checks++; if (fifo_r_en !== 1'b0) begin errors++; $display("FAIL rsthold_r_en_empty: got %b want 0", fifo_r_en); end
    $display("test_reset_hold: reset dropped held frame");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hunt();
    test_checksum();
    test_empty_toggle();
    test_hold();
    test_sync_clr();
    test_reset_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/package_frame_sequencer.md
Name: package_frame_sequencer

Overview:
- Sits between the BlueTooth controller's response FIFO and the threshold-cutter window writer.
- Pulls bytes from the FIFO one at a time and hunts for the package start byte.
- Validates each PACKAGE_SIZE-byte package by its checksum, and assembles PACKAGE_NUM consecutive good packages into one frame.
- Presents the frame on a valid/ready handshake, and counts sync and checksum errors for debug.

Parameters:
- DATA_WIDTH, 8: FIFO byte width.
- PACKAGE_SIZE, 11: bytes per package; start byte, 9 payload bytes, checksum byte.
- PACKAGE_NUM, 4: packages per frame.
- START_BYTE, 8'h55: package start marker.
- PKG_IDX_WIDTH, 2: width of the package index; must satisfy 2**PKG_IDX_WIDTH >= PACKAGE_NUM.
- FRAME_WIDTH, PACKAGE_SIZE*PACKAGE_NUM*DATA_WIDTH (352): width of the output frame.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: reset, asynchronous, active-low.
- sync_clr, input, 1: synchronous flush of the FSM, frame and counters.
- fifo_empty, input, 1: response FIFO empty.
- fifo_r_en, output, 1: FIFO read strobe, single-cycle pulse.
- fifo_data_i, input, DATA_WIDTH: FIFO read data; valid the cycle after fifo_r_en.
- frame_o, output, FRAME_WIDTH: assembled frame; first byte received is in the MSBs.
- frame_vld, output, 1: frame valid.
- frame_rdy, input, 1: consumer accepts the frame.
- pkg_idx_o, output, PKG_IDX_WIDTH: index of the package currently being collected.
- sync_err_cnt, output, 8: count of non-start bytes discarded while hunting; saturates at 255.
- sum_err_cnt, output, 8: count of checksum failures; saturates at 255.

Behaviour:
- Reset (rst_n low, asynchronous): state HUNT; all outputs 0, including fifo_r_en, frame_o, frame_vld, pkg_idx_o and both counters; internal byte counter, checksum accumulator and rd_pending flag also 0.
- Read discipline:
  - At most one outstanding read. fifo_r_en=1 for one cycle only when fifo_empty=0, rd_pending=0 and state is not HOLD.
  - rd_pending sets with fifo_r_en. On the next edge fifo_data_i is captured and rd_pending clears.
  - Peak rate is therefore 1 byte per 2 cycles.
- State HUNT:
  - Captured byte == START_BYTE: shift it into the frame, set sum=START_BYTE, byte_cnt=1, go to BODY.
  - Any other byte: drop it, sync_err_cnt+1 (saturating), stay in HUNT.
- State BODY:
  - Capture with byte_cnt < PACKAGE_SIZE-1: shift the byte into the frame, sum += byte (mod 256), byte_cnt+1.
  - Capture with byte_cnt == PACKAGE_SIZE-1 (checksum byte), compared against the accumulated sum:
    - Match, pkg_idx_o < PACKAGE_NUM-1: shift the byte in, pkg_idx_o+1, go to HUNT.
    - Match, pkg_idx_o == PACKAGE_NUM-1: shift the byte in, frame_vld=1 at the same edge, go to HOLD. frame_vld therefore rises on the edge capturing the last byte.
    - Mismatch: discard the whole partial frame (frame_o is not cleared but is invalid), pkg_idx_o=0, sum_err_cnt+1 (saturating), go to HUNT.
  - Checksum is the low 8 bits of the sum of bytes 0..PACKAGE_SIZE-2.
- Frame shifting: frame <= {frame[FRAME_WIDTH-DATA_WIDTH-1:0], byte}. It spans exactly the frame's bytes, with no shift beyond a completed frame.
- State HOLD:
  - frame_o stable and frame_vld=1 until frame_vld && frame_rdy.
  - On that edge: frame_vld=0, pkg_idx_o=0, go to HUNT.
  - No FIFO reads in HOLD; the FIFO may fill, and overflow is the producer's concern.
- frame_rdy while frame_vld=0 has no effect.
- sync_clr (synchronous, highest priority):
  - Next edge: state HUNT, rd_pending=0, frame_vld=0, pkg_idx_o=0, both counters 0.
  - A byte returning from a read issued the previous cycle is dropped.
  - sync_clr wins over a coincident handshake or byte capture.
- rst_n asserted mid-package or in HOLD: immediate return to the reset values. The partial frame is lost and no frame_vld glitch is permitted.

Test Plan:
- Four back-to-back packages 55 51 01 00 02 00 03 00 04 00 B0, frame_rdy=1 -> frame_vld=1 for exactly one cycle; frame_o[351:344]=8'h55, frame_o[7:0]=8'hB0; no errors counted.
- Leading bytes 00 AA 13 then a valid 4-package stream -> sync_err_cnt=3; frame delivered unchanged.
- Package 2 checksum byte = B1 -> sum_err_cnt=1, pkg_idx_o returns to 0, and no frame until 4 further good packages.
- frame_rdy=0 for 20 cycles after frame_vld -> frame_o stable, fifo_r_en stays 0 with a non-empty FIFO; frame_rdy=1 -> frame_vld drops next edge and reads resume.
- fifo_empty toggled every cycle during a frame -> fifo_r_en never asserted while empty or while rd_pending; frame correct.
- sync_clr in BODY with pkg_idx_o=2 -> next cycle HUNT, pkg_idx_o=0, counters 0; rst_n pulse in HOLD -> frame_vld=0 immediately.
